// File: rtl/tt_selftest_harness_if.sv
// ---------------------------------------------------------------------------
// tt_selftest_harness_if
//   Bus bundle between the self-test harness and whoever drives it (pad
//   logic or a bench). clk/rst are not part of the bundle.
//   master : drives ena, cfg_*, num_vec, start, resp_in (and loop)
//   slave  : the harness; drives stim_out, busy, done, pass, err_count,
//            first_fail_idx (and pass_count)
//   Optional macro HARNESS_LOOP_EN adds loop / pass_count.
// ---------------------------------------------------------------------------
interface tt_selftest_harness_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             ena;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_stim;
  logic [WIDTH-1:0] cfg_exp;
  logic [AW:0]      num_vec;
  logic             start;
  logic [WIDTH-1:0] stim_out;
  logic [WIDTH-1:0] resp_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [AW:0]      err_count;
  logic [AW-1:0]    first_fail_idx;
`ifdef HARNESS_LOOP_EN
  logic             loop;
  logic [7:0]       pass_count;

  modport master (
    output ena, cfg_we, cfg_addr, cfg_stim, cfg_exp, num_vec, start, resp_in, loop,
    input  stim_out, busy, done, pass, err_count, first_fail_idx, pass_count
  );
  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_stim, cfg_exp, num_vec, start, resp_in, loop,
    output stim_out, busy, done, pass, err_count, first_fail_idx, pass_count
  );
`else
  modport master (
    output ena, cfg_we, cfg_addr, cfg_stim, cfg_exp, num_vec, start, resp_in,
    input  stim_out, busy, done, pass, err_count, first_fail_idx
  );
  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_stim, cfg_exp, num_vec, start, resp_in,
    output stim_out, busy, done, pass, err_count, first_fail_idx
  );
`endif
endinterface

// File: rtl/tt_selftest_harness.sv
// ---------------------------------------------------------------------------
// tt_selftest_harness
//   On-chip stimulus/response replayer. A DEPTH-entry table of
//   {stimulus, expected} pairs is played out on stim_out, one vector every
//   LATENCY clocks; the DUT response on resp_in is compared against the
//   expected value on the last edge of each vector slot. Mismatches are
//   counted (saturating) and the first failing index is recorded.
//
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     bus (slave)    ena, cfg_we/cfg_addr/cfg_stim/cfg_exp, num_vec, start,
//                    resp_in in; stim_out, busy, done, pass, err_count,
//                    first_fail_idx out
//
//   Optional macro HARNESS_LOOP_EN: adds bus.loop (repeat the table while
//   high) and bus.pass_count (completed passes, saturating at 255).
//
//   The vector memory has no reset so a table survives a mid-run reset.
// ---------------------------------------------------------------------------
module tt_selftest_harness #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  tt_selftest_harness_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(LATENCY - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [AW:0]      n_q, n_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic             pass_q, pass_d;
  logic [AW:0]      err_q, err_d;
  logic [AW-1:0]    ffi_q, ffi_d;
`ifdef HARNESS_LOOP_EN
  logic [7:0]       pc_q, pc_d;
`endif

  // {stim, exp} per slot
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic [WIDTH-1:0] stim0;
  logic [WIDTH-1:0] exp_cur;
  logic [WIDTH-1:0] stim_next;
  logic [AW-1:0]    idx_inc;
  logic             mismatch;
  logic             last_vec;
  logic [AW:0]      err_inc;
  logic [AW:0]      n_clamp;

  // Writes are only accepted while no run is in flight.
  assign wr_en = bus.ena & bus.cfg_we & (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[bus.cfg_addr] <= {bus.cfg_stim, bus.cfg_exp};
  end

  always_comb begin
    idx_inc   = idx_q + 1'b1;
    // A same-edge write to slot 0 must be visible to the starting run.
    stim0     = (wr_en && bus.cfg_addr == '0) ? bus.cfg_stim : mem_q[0][2*WIDTH-1:WIDTH];
    exp_cur   = mem_q[idx_q][WIDTH-1:0];
    stim_next = mem_q[idx_inc][2*WIDTH-1:WIDTH];
    mismatch  = (bus.resp_in != exp_cur);
    last_vec  = ({1'b0, idx_q} == (n_q - 1'b1));
    err_inc   = (err_q == '1) ? err_q : err_q + 1'b1;
    if (bus.num_vec == '0)          n_clamp = (AW+1)'(1);
    else if (bus.num_vec > DEPTH_W) n_clamp = DEPTH_W;
    else                            n_clamp = bus.num_vec;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    n_d     = n_q;
    stim_d  = stim_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
`ifdef HARNESS_LOOP_EN
    pc_d    = pc_q;
`endif
    // ena low freezes everything, including the latency counter.
    if (bus.ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d = S_RUN;
            idx_d   = '0;
            lat_d   = '0;
            n_d     = n_clamp;
            stim_d  = stim0;
            pass_d  = 1'b0;
            err_d   = '0;
            ffi_d   = '0;
`ifdef HARNESS_LOOP_EN
            pc_d    = '0;
`endif
          end
        end
        S_RUN: begin
          lat_d = lat_q + 1'b1;
          // Last edge of the vector slot: sample the response.
          if (lat_q == LAT_LAST) begin
            lat_d = '0;
            if (mismatch) begin
              err_d = err_inc;
              // err_q is zero only until the first mismatch of the run.
              if (err_q == '0) ffi_d = idx_q;
            end
            if (last_vec) begin
`ifdef HARNESS_LOOP_EN
              pc_d = (pc_q == 8'hFF) ? pc_q : pc_q + 1'b1;
              if (bus.loop) begin
                idx_d  = '0;
                stim_d = stim0;
              end else begin
                state_d = S_DONE;
                pass_d  = (err_d == '0);
              end
`else
              state_d = S_DONE;
              pass_d  = (err_d == '0);
`endif
            end else begin
              idx_d  = idx_inc;
              stim_d = stim_next;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      n_q     <= '0;
      stim_q  <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
`ifdef HARNESS_LOOP_EN
      pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      n_q     <= n_d;
      stim_q  <= stim_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
`ifdef HARNESS_LOOP_EN
      pc_q    <= pc_d;
`endif
    end
  end

  assign bus.stim_out       = stim_q;
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;
`ifdef HARNESS_LOOP_EN
  assign bus.pass_count     = pc_q;
`endif

endmodule

// File: tb/tb_tt_selftest_harness.sv
// ---------------------------------------------------------------------------
// tb_tt_selftest_harness
//   Drives tt_selftest_harness with a one-register loopback DUT
//   (resp_in = stim_out delayed one clock), so vector k mismatches exactly
//   when its stored stimulus differs from its stored expected value. The
//   reference model is the table itself plus a count of enabled clocks.
// ---------------------------------------------------------------------------
module tb_tt_selftest_harness;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int AW  = $clog2(D);
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_selftest_harness_if #(.WIDTH(W), .DEPTH(D)) hif();

  tt_selftest_harness #(.WIDTH(W), .DEPTH(D), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  logic [W-1:0] dut_q;
  always @(posedge clk) dut_q <= hif.stim_out;
  assign hif.resp_in = dut_q;

  int nvec  = 0;
  int nfail = 0;
  logic [W-1:0] m_stim [D];
  logic [W-1:0] m_exp  [D];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".stim_out"}, 32'(hif.stim_out), 0);
    chk({tag, ".busy"},     32'(hif.busy), 0);
    chk({tag, ".done"},     32'(hif.done), 0);
    chk({tag, ".pass"},     32'(hif.pass), 0);
    chk({tag, ".err"},      32'(hif.err_count), 0);
    chk({tag, ".ffi"},      32'(hif.first_fail_idx), 0);
  endtask

  task automatic load(input int a, input logic [W-1:0] s, input logic [W-1:0] e);
    hif.ena      = 1'b1;
    hif.cfg_we   = 1'b1;
    hif.cfg_addr = AW'(a);
    hif.cfg_stim = s;
    hif.cfg_exp  = e;
    tick();
    hif.cfg_we   = 1'b0;
    m_stim[a] = s;
    m_exp[a]  = e;
  endtask

  // One run: nv = requested num_vec, disturb = start/cfg_we pulse then
  // ena low 3 clocks, rnd = random ena/start, rst_t = enabled-clock index
  // at which to assert rst (-1 none), wr0 = write slot 0 on the start edge.
  task automatic run(input int nv, input bit disturb, input bit rnd,
                     input int rst_t, input bit wr0);
    int n, t, cyc, lows, gap, exp_err, exp_ffi;
    bit dis_done, ena_now, aborted;
    logic [W-1:0] s, e;
    n = (nv == 0) ? 1 : ((nv > D) ? D : nv);
    hif.ena = 1'b1;
    if (wr0) begin
      s = W'($urandom);
      e = ($urandom_range(1) == 0) ? s : W'(s ^ 8'h5A);
      hif.cfg_we = 1'b1; hif.cfg_addr = '0; hif.cfg_stim = s; hif.cfg_exp = e;
      m_stim[0] = s; m_exp[0] = e;
    end
    hif.num_vec = (AW+1)'(nv);
    hif.start   = 1'b1;
    tick();
    hif.start  = 1'b0;
    hif.cfg_we = 1'b0;

    exp_err = 0; exp_ffi = 0;
    for (int k = 0; k < n; k++)
      if (m_stim[k] != m_exp[k]) begin
        if (exp_err == 0) exp_ffi = k;
        exp_err++;
      end

    t = 0; cyc = 0; lows = 0; gap = 0; dis_done = 0; aborted = 0;
    while (t < n*LAT && cyc < 4*n*LAT + 50 && !aborted) begin
      chk("stim_seq", 32'(hif.stim_out), 32'(m_stim[t/LAT]));
      chk("busy_run", 32'(hif.busy), 1);
      if (t == rst_t) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midrst");
        aborted = 1;
      end else begin
        hif.ena = 1'b1;
        if (gap > 0) begin
          hif.ena = 1'b0;
          gap--;
        end else if (rnd && $urandom_range(3) == 0) hif.ena = 1'b0;
        if (disturb && t == 3 && !dis_done) begin
          hif.start = 1'b1; hif.cfg_we = 1'b1; hif.cfg_addr = AW'(1);
          hif.cfg_stim = ~m_stim[1]; hif.cfg_exp = ~m_exp[1];
          dis_done = 1; gap = 3;
        end else begin
          hif.start  = rnd ? 1'($urandom_range(1)) : 1'b0;
          hif.cfg_we = 1'b0;
        end
        ena_now = hif.ena;
        tick();
        cyc++;
        if (ena_now) t++; else lows++;
      end
    end
    hif.start = 1'b0; hif.cfg_we = 1'b0; hif.ena = 1'b1;
    if (!aborted) begin
      chk("run_complete", 32'(t), 32'(n*LAT));
      chk("run_len", 32'(cyc), 32'(n*LAT + lows));
      chk("done", 32'(hif.done), 1);
      chk("busy_end", 32'(hif.busy), 0);
      chk("pass", 32'(hif.pass), 32'(exp_err == 0));
      chk("err_count", 32'(hif.err_count), 32'(exp_err));
      chk("first_fail", 32'(hif.first_fail_idx), 32'(exp_ffi));
      chk("stim_hold", 32'(hif.stim_out), 32'(m_stim[n-1]));
`ifdef HARNESS_LOOP_EN
      chk("pass_count1", 32'(hif.pass_count), 1);
`endif
      tick();
      chk("done_hold", 32'(hif.done), 1);
    end
  endtask

  initial begin
    hif.ena = 1'b0; hif.cfg_we = 1'b0; hif.cfg_addr = '0;
    hif.cfg_stim = '0; hif.cfg_exp = '0; hif.num_vec = '0; hif.start = 1'b0;
`ifdef HARNESS_LOOP_EN
    hif.loop = 1'b0;
`endif
    // reset with random control inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hif.ena = 1'($urandom_range(1)); hif.start = 1'($urandom_range(1));
      hif.num_vec = (AW+1)'($urandom); hif.cfg_stim = W'($urandom);
      tick();
    end
    rst = 1'b0; hif.start = 1'b0; hif.ena = 1'b1;
    chk_reset_vals("reset");

    // fill the whole table with matching pairs, then the directed vectors
    for (int a = 0; a < D; a++) begin
      logic [W-1:0] r;
      r = W'($urandom);
      load(a, r, r);
    end
    load(0, 8'h11, 8'h11); load(1, 8'h22, 8'h22);
    load(2, 8'h33, 8'h33); load(3, 8'h44, 8'h44);
    run(4, 0, 0, -1, 0);

    load(2, 8'h33, 8'h00); load(3, 8'h44, 8'h00);
    run(4, 0, 0, -1, 0);
    chk("dir_err2", 32'(hif.err_count), 2);
    chk("dir_ffi2", 32'(hif.first_fail_idx), 2);

    load(2, 8'h33, 8'h33); load(3, 8'h44, 8'h44);
    run(0, 0, 0, -1, 0);
    run(D + 5, 0, 0, -1, 0);

    // start/cfg_we ignored while busy, ena low 3 clocks stretches the run
    run(4, 1, 0, -1, 0);
    run(4, 0, 0, -1, 0);

    // reset mid-run, then a full run from retained memory
    run(4, 0, 0, 3, 0);
    run(4, 0, 0, -1, 0);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        int a;
        logic [W-1:0] s, e;
        a = $urandom_range(D - 1);
        s = W'($urandom);
        e = ($urandom_range(3) == 0) ? W'(s ^ W'($urandom_range(255, 1))) : s;
        load(a, s, e);
      end
      run($urandom_range(D + 8), 0, 1, -1, 1'($urandom_range(1)));
    end

`ifdef HARNESS_LOOP_EN
    begin
      int t, cyc;
      load(0, 8'hA1, 8'hA1); load(1, 8'hB2, 8'h00);
      load(2, 8'hC3, 8'hC3); load(3, 8'hD4, 8'hD4);
      hif.loop = 1'b1; hif.num_vec = (AW+1)'(4); hif.start = 1'b1;
      tick();
      hif.start = 1'b0;
      t = 0; cyc = 0;
      while (t < 3*4*LAT && cyc < 200) begin tick(); t++; cyc++; end
      chk("loop_busy", 32'(hif.busy), 1);
      chk("loop_err3", 32'(hif.err_count), 3);
      chk("loop_ffi", 32'(hif.first_fail_idx), 1);
      chk("loop_pc3", 32'(hif.pass_count), 3);
      hif.loop = 1'b0;
      while (t < 4*4*LAT && cyc < 200) begin tick(); t++; cyc++; end
      chk("loop_done", 32'(hif.done), 1);
      chk("loop_err4", 32'(hif.err_count), 4);
      chk("loop_pc4", 32'(hif.pass_count), 4);
      chk("loop_pass", 32'(hif.pass), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
